// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Summary  : EX-stage multiply/divide unit that owns the HI/LO registers.
//            Define MD_MADD_EN to turn md_op 6/7 into MADD/MSUB.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_N = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_N  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MSUB  = 3'd7;
`endif

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [63:0]        r_pend;
    logic               r_dz;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_launch;
    logic               w_done;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_dz;
    logic [c_CNT_W-1:0] w_n;
    logic [63:0]        w_res;

    // Arithmetic datapath, evaluated on the live operands at the start edge.
    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic        w_sdiv;
    logic [31:0] w_amag;
    logic [31:0] w_bmag;
    logic [31:0] w_dnd;
    logic [31:0] w_dsr;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_umul = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes, so MIN_INT / -1 wraps to MIN_INT.
    assign w_sdiv = (md_op == c_OP_DIV);
    assign w_amag = a[31] ? (32'd0 - a) : a;
    assign w_bmag = b[31] ? (32'd0 - b) : b;
    assign w_dnd  = w_sdiv ? w_amag : a;
    assign w_dsr  = (b == 32'd0) ? 32'd1 : (w_sdiv ? w_bmag : b);
    assign w_q    = w_dnd / w_dsr;
    assign w_r    = w_dnd % w_dsr;
    assign w_quo  = (w_sdiv && (a[31] ^ b[31])) ? (32'd0 - w_q) : w_q;
    assign w_rem  = (w_sdiv && a[31]) ? (32'd0 - w_r) : w_r;

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        w_dz        = 1'b0;
        w_n         = c_MULT_N;
        w_res       = 64'd0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    case (md_op)
                        c_OP_MULT: begin
                            w_launch = 1'b1;
                            w_res    = w_smul;
                        end
                        c_OP_MULTU: begin
                            w_launch = 1'b1;
                            w_res    = w_umul;
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            w_launch = 1'b1;
                            w_n      = c_DIV_N;
                            w_dz     = (b == 32'd0);
                            w_res    = {w_rem, w_quo};
                        end
                        c_OP_MTHI: w_mthi = 1'b1;
                        c_OP_MTLO: w_mtlo = 1'b1;
`ifdef MD_MADD_EN
                        c_OP_MADD: begin
                            w_launch = 1'b1;
                            w_res    = {r_hi, r_lo} + w_smul;
                        end
                        c_OP_MSUB: begin
                            w_launch = 1'b1;
                            w_res    = {r_hi, r_lo} - w_smul;
                        end
`endif
                        default: ;
                    endcase
                    if (w_launch) begin
                        w_state_nxt = c_BUSY;
                    end
                end
            end
            default: begin
                if (r_cnt <= c_ONE) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_pend <= 64'd0;
            r_dz   <= 1'b0;
            r_busy <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else if (w_launch) begin
            r_cnt  <= w_n;
            r_pend <= w_res;
            r_dz   <= w_dz;
            r_busy <= 1'b1;
        end else if (r_state == c_BUSY) begin
            r_cnt <= r_cnt - c_ONE;
            if (w_done) begin
                r_busy <= 1'b0;
                // A zero divisor burns the cycles but leaves HI/LO intact.
                if (!r_dz) begin
                    r_hi <= r_pend[63:32];
                    r_lo <= r_pend[31:0];
                end
            end
        end else begin
            if (w_mthi) r_hi <= a;
            if (w_mtlo) r_lo <= a;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module   : tb_md_unit
// Summary  : Table-driven checks of md_unit plus hand-written corner sequences.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        int          cyc;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after busy drops.
    task automatic run_op(input vec_t v);
        int cnt;
        start = 1'b1;
        md_op = v.op;
        a     = v.va;
        b     = v.vb;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cnt   = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk({v.name, "_busy_len"}, 32'(cnt), 32'(v.cyc));
        chk({v.name, "_hi"}, hi, v.ehi);
        chk({v.name, "_lo"}, lo, v.elo);
    endtask

    initial begin
        int          cnt;
        logic [31:0] prev_lo;

        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        md_op  = 3'd0;
        a      = 32'd0;
        b      = 32'd0;

        vecs[0]  = '{"mult_neg",  3'd0, 32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{"multu",     3'd1, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{"div_neg",   3'd2, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu",      3'd3, 32'd7,        32'd2,        10, 32'd1,        32'd3};
        vecs[4]  = '{"divu_zero", 3'd3, 32'd7,        32'd0,        10, 32'd1,        32'd3};
        vecs[5]  = '{"div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000};
        vecs[6]  = '{"mult_max",  3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
        vecs[7]  = '{"div_negb",  3'd2, 32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{"mthi",      3'd4, 32'h12345678, 32'd9,        0,  32'h12345678, 32'hFFFFFFFD};
        vecs[9]  = '{"mtlo",      3'd5, 32'h0000CAFE, 32'd9,        0,  32'h12345678, 32'h0000CAFE};
`ifdef MD_MADD_EN
        vecs[10] = '{"madd",      3'd6, 32'd2,        32'd3,        5,  32'h12345678, 32'h0000CB04};
        vecs[11] = '{"msub",      3'd7, 32'd2,        32'd3,        5,  32'h12345678, 32'h0000CAFE};
`else
        vecs[10] = '{"rsvd6",     3'd6, 32'd2,        32'd3,        0,  32'h12345678, 32'h0000CAFE};
        vecs[11] = '{"rsvd7",     3'd7, 32'd2,        32'd3,        0,  32'h12345678, 32'h0000CAFE};
`endif

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_op(vecs[i]);

        // DIV 100/7 with an MTLO and operand churn while busy.
        prev_lo = lo;
        start = 1'b1;
        md_op = 3'd2;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (cnt == 2) begin
                start = 1'b1;
                md_op = 3'd5;
                a     = 32'h0000DEAD;
            end else if (cnt == 3) begin
                start = 1'b0;
                a     = 32'd0;
                b     = 32'd0;
                chk("busy_mtlo_lo", lo, prev_lo);
            end
            @(negedge clk);
        end
        chk("busy_mtlo_len", 32'(cnt), 32'd10);
        chk("busy_mtlo_hi", hi, 32'd2);
        chk("busy_mtlo_lo_res", lo, 32'd14);

        // Asynchronous reset in the middle of a MULT.
        start = 1'b1;
        md_op = 3'd0;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_lo", lo, 32'd0);
        run_op('{"multu_after_rst", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
